// File: rtl/cmos_pixel_packer.sv
// CMOS camera byte stream to 32-bit FIFO word packer with frame/line counters.
// Optional macro CMOS_FRAME_HEADER_EN writes a {16'hA5A5, frame_cnt} word at frame start.
module cmos_pixel_packer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PIX_WIDTH  = 8
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  capture_en,
  input  logic                  cmos_vsync,
  input  logic                  cmos_href,
  input  logic [PIX_WIDTH-1:0]  cmos_data,
  input  logic                  fifo_full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] din,
  output logic [15:0]           frame_cnt,
  output logic [11:0]           line_cnt,
  output logic                  overflow,
  output logic                  busy
);

  localparam int unsigned NUM_PIX  = DATA_WIDTH / PIX_WIDTH;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned LOW_W    = DATA_WIDTH - PIX_WIDTH;
  localparam logic [11:0] LINE_MAX = 12'hFFF;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_CAPTURE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_vs, r_vs_d, r_href, r_href_d;
  logic [PIX_WIDTH-1:0]  r_data;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_pack;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_pend;

  logic             w_vs_fall, w_vs_rise, w_href_rise, w_href_fall;
  logic             w_accept, w_flush, w_enter, w_start, w_close;
  logic [IDX_W-1:0] w_idx;

  assign w_vs_fall   = r_vs_d & ~r_vs;
  assign w_vs_rise   = ~r_vs_d & r_vs;
  assign w_href_rise = r_href & ~r_href_d;
  assign w_href_fall = r_href_d & ~r_href;
  assign w_idx       = w_href_rise ? '0 : r_idx;
  assign w_accept    = (r_state == S_CAPTURE) & r_href;
  assign w_flush     = (r_state == S_CAPTURE) & w_href_fall & (r_idx != '0);
  assign w_enter     = (r_state != S_CAPTURE) & (w_state_nxt == S_CAPTURE);
  assign w_start     = (r_state == S_IDLE) & (w_state_nxt == S_WAIT_VS);
  assign w_close     = (r_state == S_CAPTURE) & (w_state_nxt != S_CAPTURE);

  // Next-state logic; a frame in progress only ends on a vsync rise.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (capture_en) w_state_nxt = S_WAIT_VS;
      S_WAIT_VS: begin
        if (!capture_en)    w_state_nxt = S_IDLE;
        else if (w_vs_fall) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: if (w_vs_rise) w_state_nxt = capture_en ? S_WAIT_VS : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Input registers, byte packing and the one-deep write pipeline.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      r_vs      <= 1'b0;
      r_vs_d    <= 1'b0;
      r_href    <= 1'b0;
      r_href_d  <= 1'b0;
      r_data    <= '0;
      r_idx     <= '0;
      r_pack    <= '0;
      r_word    <= '0;
      r_pend    <= 1'b0;
      wr_en     <= 1'b0;
      din       <= '0;
      frame_cnt <= '0;
      line_cnt  <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_vs     <= cmos_vsync;
      r_vs_d   <= r_vs;
      r_href   <= cmos_href;
      r_href_d <= r_href;
      r_data   <= cmos_data;
      r_pend   <= 1'b0;
      if (w_href_rise) r_idx <= '0;

      if (w_accept) begin
        if (w_idx == IDX_W'(NUM_PIX - 1)) begin
          r_word <= {r_data, r_pack[LOW_W-1:0]};
          r_pend <= 1'b1;
          r_idx  <= '0;
        end else begin
          if (w_idx == '0) r_pack <= DATA_WIDTH'(r_data);
          for (int i = 1; i < NUM_PIX; i++)
            if (w_idx == IDX_W'(i)) r_pack[i*PIX_WIDTH +: PIX_WIDTH] <= r_data;
          r_idx <= w_idx + IDX_W'(1);
        end
      end else if (w_flush) begin
        r_word <= r_pack;
        r_pend <= 1'b1;
        r_idx  <= '0;
      end
`ifdef CMOS_FRAME_HEADER_EN
      else if (w_enter) begin
        r_word <= DATA_WIDTH'({16'hA5A5, frame_cnt});
        r_pend <= 1'b1;
      end
`endif

      wr_en <= r_pend & ~fifo_full;
      if (r_pend && !fifo_full) din <= r_word;

      if (w_start)                overflow <= 1'b0;
      else if (r_pend && fifo_full) overflow <= 1'b1;

      if (w_enter) line_cnt <= '0;
      else if ((r_state == S_CAPTURE) && w_href_fall && (line_cnt != LINE_MAX))
        line_cnt <= line_cnt + 12'd1;

      if (w_close) frame_cnt <= frame_cnt + 16'd1;

      busy <= (w_state_nxt == S_CAPTURE);
    end
  end

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Scoreboard bench for cmos_pixel_packer; expected words queued as lines are driven.
module tb_cmos_pixel_packer;

  logic        wr_clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture_en = 1'b0;
  logic        cmos_vsync = 1'b1;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_data = 8'h00;
  logic        fifo_full = 1'b0;
  logic        wr_en;
  logic [31:0] din;
  logic [15:0] frame_cnt;
  logic [11:0] line_cnt;
  logic        overflow;
  logic        busy;

`ifdef CMOS_FRAME_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          grp_cyc = 0;
  logic [15:0] exp_frame = 16'd0;
  logic [7:0]  line_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          obs_cyc[$];

  cmos_pixel_packer #(.DATA_WIDTH(32), .PIX_WIDTH(8)) dut (
    .wr_clk(wr_clk), .rst(rst), .capture_en(capture_en), .cmos_vsync(cmos_vsync),
    .cmos_href(cmos_href), .cmos_data(cmos_data), .fifo_full(fifo_full),
    .wr_en(wr_en), .din(din), .frame_cnt(frame_cnt), .line_cnt(line_cnt),
    .overflow(overflow), .busy(busy)
  );

  always #5 wr_clk = ~wr_clk;
  always @(posedge wr_clk) cyc <= cyc + 1;

  // Collect every FIFO write away from the active edge.
  always @(negedge wr_clk) begin
    if (wr_en) begin
      obs_q.push_back(din);
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge wr_clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference packing of line_q: LSB byte first, partial tail zero-padded.
  task automatic push_model();
    logic [31:0] w;
    for (int g = 0; g < line_q.size(); g += 4) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++)
        if (g + k < line_q.size()) w[k*8 +: 8] = line_q[g+k];
      exp_q.push_back(w);
    end
  endtask

  task automatic start_frame();
    capture_en = 1'b1;
    cmos_vsync = 1'b1;
    step(3);
    cmos_vsync = 1'b0;
`ifdef CMOS_FRAME_HEADER_EN
    exp_q.push_back({16'hA5A5, exp_frame});
`endif
    step(4);
  endtask

  task automatic close_frame(input logic keep_en);
    capture_en = keep_en;
    cmos_vsync = 1'b1;
    exp_frame  = exp_frame + 16'd1;
    step(4);
  endtask

  task automatic send_line(input int full_at, input logic close_with_vs);
    for (int i = 0; i < line_q.size(); i++) begin
      if (i == full_at) fifo_full = 1'b1;
      cmos_href = 1'b1;
      cmos_data = line_q[i];
      if (i == 3) grp_cyc = cyc;
      step();
    end
    cmos_href = 1'b0;
    cmos_data = 8'h00;
    if (close_with_vs) begin
      cmos_vsync = 1'b1;
      exp_frame  = exp_frame + 16'd1;
    end
    step(4);
    fifo_full = 1'b0;
  endtask

  task automatic check_writes(input string name);
    int n;
    step(2);
    chk({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, "_word"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic set_line(input logic [7:0] first, input int n);
    line_q.delete();
    for (int i = 0; i < n; i++) line_q.push_back(first + 8'(i));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step();
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_din", din, 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    chk("rst_line_cnt", 32'(line_cnt), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
  endtask

  task automatic test_basic();
    start_frame();
    chk("basic_busy", 32'(busy), 32'h1);
    set_line(8'h01, 8);
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    send_line(-1, 1'b0);
    checks++;
    if (obs_cyc.size() < HDR + 1 || obs_cyc[HDR] != grp_cyc + 3) begin
      failures++;
      $display("FAIL basic_latency actual=%0d required=%0d",
               (obs_cyc.size() > HDR) ? obs_cyc[HDR] - grp_cyc : -1, 3);
    end
    chk("basic_line_cnt", 32'(line_cnt), 32'h1);
    check_writes("basic");
  endtask

  task automatic test_partial();
    set_line(8'h11, 6);
    exp_q.push_back(32'h14131211);
    exp_q.push_back(32'h00001615);
    send_line(-1, 1'b0);
    chk("partial_line_cnt", 32'(line_cnt), 32'h2);
    check_writes("partial");
    close_frame(1'b1);
    chk("close_frame_cnt", 32'(frame_cnt), 32'(exp_frame));
    chk("close_busy", 32'(busy), 32'h0);
  endtask

  task automatic test_ignore_outside();
    set_line(8'h40, 7);
    send_line(-1, 1'b0);
    check_writes("ignore");
  endtask

  task automatic test_overflow();
    start_frame();
    chk("ovf_line_clr", 32'(line_cnt), 32'h0);
    set_line(8'h01, 8);
    exp_q.push_back(32'h04030201);
    send_line(6, 1'b0);
    chk("ovf_set", 32'(overflow), 32'h1);
    set_line(8'h21, 4);
    exp_q.push_back(32'h24232221);
    send_line(-1, 1'b0);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    check_writes("ovf");
    close_frame(1'b1);
    chk("ovf_frame_cnt", 32'(frame_cnt), 32'(exp_frame));
    chk("ovf_wait_vs_hold", 32'(overflow), 32'h1);
  endtask

  task automatic test_capture_drop();
    start_frame();
    capture_en = 1'b0;
    set_line(8'h51, 7);
    push_model();
    send_line(-1, 1'b0);
    chk("drop_busy_mid", 32'(busy), 32'h1);
    set_line(8'h61, 3);
    push_model();
    send_line(-1, 1'b1);
    check_writes("drop");
    chk("drop_frame_cnt", 32'(frame_cnt), 32'(exp_frame));
    chk("drop_busy", 32'(busy), 32'h0);
    chk("drop_ovf_idle", 32'(overflow), 32'h1);
    capture_en = 1'b1;
    step(2);
    chk("drop_ovf_clear", 32'(overflow), 32'h0);
  endtask

  task automatic test_reset_midframe();
    start_frame();
    cmos_href = 1'b1;
    cmos_data = 8'h77;
    step();
    cmos_data = 8'h78;
    step();
    rst = 1'b1;
    cmos_href = 1'b0;
    capture_en = 1'b0;
    exp_frame = 16'd0;
    step(2);
    rst = 1'b0;
    step(3);
    chk("mrst_din", din, 32'h0);
    chk("mrst_frame_cnt", 32'(frame_cnt), 32'h0);
    chk("mrst_line_cnt", 32'(line_cnt), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_overflow", 32'(overflow), 32'h0);
    check_writes("mrst");
    start_frame();
    set_line(8'h31, 4);
    exp_q.push_back(32'h34333231);
    send_line(-1, 1'b0);
    check_writes("mrst_next");
    close_frame(1'b1);
    start_frame();
    set_line(8'h81, 5);
    push_model();
    send_line(-1, 1'b0);
    check_writes("frame2");
    chk("frame2_cnt", 32'(frame_cnt), 32'h1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_ignore_outside();
    test_overflow();
    test_capture_drop();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
